week6_ex1_rr_arbiter: RTL and testbench
=======================================

# week6_ex1_rr_arbiter

Four-requester round-robin arbiter with a registered one-hot grant and a valid/ack handshake. It sits directly upstream of the week5 4-to-2 encoder. Its `gnt` output is guaranteed one-hot or all-zero, which is the only input class the encoder decodes unambiguously. The encoder then turns the grant into a 2-bit channel index for the downstream datapath.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive acked grants one requester may keep. Used only when `ARB_LOCK_EN` is defined. Legal range 1–15.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  4  request lines; bit i is requester i; level-sensitive.
- `ack`  in  1  downstream has consumed the current grant; qualified by `gnt_valid`.
- `gnt`  out  4  registered grant; one-hot while `gnt_valid`=1, else 4'b0000.
- `gnt_valid`  out  1  registered; high exactly when `gnt` is non-zero.

## Operation
Reset values, applied on the clock edge where `rst`=1:
- `gnt`=0000, `gnt_valid`=0
- `ptr`=0, so requester 0 has highest priority
- `hold_cnt`=0
- state IDLE

Reset overrides every other input, including reset asserted mid-grant.

Pick function:
- Search `req` starting at index `ptr` and rotating upward modulo 4.
- The first set bit wins.

State machine:
- IDLE
  - If `req`≠0: register the pick into `gnt`, set `gnt_valid`=1, go to GRANT.
  - Else stay in IDLE with outputs zero.
- GRANT
  - `gnt` is held stable until a cycle where `ack`=1.
  - Dropping the granted `req` bit does not revoke the grant; a grant is a commitment.
  - On `ack`=1, with granted index g:
    - `ptr` ← (g+1) mod 4, so g becomes lowest priority.
    - Re-pick from the same-cycle `req` using the new `ptr`.
    - If the pick is non-zero, load it and stay in GRANT (back-to-back, no bubble cycle).
    - Otherwise clear `gnt`/`gnt_valid` and go to IDLE.
- `ack` while `gnt_valid`=0 is ignored.

Pointer arithmetic: `ptr` is 2 bits and wraps 3→0 naturally.

## Timing
- Request latency: `req` first seen in IDLE at cycle t → `gnt`/`gnt_valid` valid at cycle t+1.
- Handover latency: `ack` at cycle t → next grant, or zero, at t+1.
- No combinational path from `req` or `ack` to any output; all outputs come straight from flops.
- Simultaneous requests are resolved by `ptr` only. No requester is starved: each waits at most 3 grants.

## Configuration
- `ARB_LOCK_EN` defined: on `ack`, if requester g still has `req[g]`=1 and `hold_cnt` < `MAX_HOLD`−1:
  - keep `gnt` unchanged and `gnt_valid`=1;
  - increment `hold_cnt`;
  - leave `ptr` unchanged.
- Otherwise, with the macro defined, release as normal and clear `hold_cnt` to 0.
- `hold_cnt` also clears whenever a different requester is granted.
- `ARB_LOCK_EN` undefined: `hold_cnt` logic and `MAX_HOLD` are absent. Every ack rotates priority as described in Operation.

## Structure
- Shared package `week6_pkg` holds:
  - `N_REQ`=4
  - state typedef `arb_state_t` {IDLE, GRANT}
- Sub-module `week6_rr_pick`: purely combinational rotate-and-priority pick (inputs `req`, `ptr`; output one-hot `pick`). It is instantiated once and reused for both the IDLE and GRANT-handover decisions.

## Test plan
- Reset: hold `rst`=1 with `req`=1111 → `gnt`=0000, `gnt_valid`=0 every cycle; release `rst` → cycle after, `gnt`=0001.
- Rotation: `req`=1111 constant, `ack`=1 constant, lock off → `gnt` sequence 0001, 0010, 0100, 1000, 0001.
- Sparse/wrap: `ptr`=3 after a grant to 2, `req`=0011 → `gnt`=0001; ack → `gnt`=0010.
- Hold without ack: grant 0100, then drop `req` to 0000 while `ack`=0 for 5 cycles → `gnt` stays 0100; `ack`=1 → next cycle `gnt`=0000, `gnt_valid`=0, state IDLE.
- Lock (`ARB_LOCK_EN`, `MAX_HOLD`=3): `req`=0011, `ack`=1 constant → `gnt` 0001, 0001, 0001, 0010.
- Chain with encoder: feed `gnt` into the week5 encoder for the rotation stimulus → encoder `out` sequence 00, 01, 10, 11.

Source files
------------

// File: rtl/week6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : week6_pkg
// Description : Shared constants, state type and a one-hot to index helper
//               for the four-requester round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package week6_pkg;

    localparam int N_REQ = 4;
    localparam int PTR_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : week6_pkg
`default_nettype wire

// File: rtl/week6_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : week6_rr_pick
// Description : Combinational rotate-and-priority pick. Searches req starting
//               at index ptr, rotating upward modulo N_REQ; the first set bit
//               wins and is returned as a one-hot vector.
// Ports       : req  [N_REQ-1:0] in  request lines
//               ptr  [PTR_W-1:0] in  highest-priority index
//               pick [N_REQ-1:0] out one-hot winner, or zero if req is zero
// Revision    : 1.0 - initial release
// ============================================================================
module week6_rr_pick
    import week6_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        w_idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            // The 2-bit add wraps 3 -> 0, giving the modulo-4 rotation.
            w_idx = ptr + PTR_W'(k);
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule : week6_rr_pick
`default_nettype wire

// File: rtl/week6_ex1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : week6_ex1_rr_arbiter
// Description : Four-requester round-robin arbiter with a registered one-hot
//               grant and a valid/ack handshake. A grant is held until ack;
//               on ack priority rotates past the granted requester and a new
//               grant is loaded in the same cycle (no bubble).
// Config      : ARB_LOCK_EN - when defined, a requester that still requests
//               on ack keeps the grant for up to MAX_HOLD consecutive acked
//               grants (parameter MAX_HOLD, legal 1..15). When undefined the
//               hold counter and MAX_HOLD do not exist.
// Ports       : clk        in  1  rising-edge clock
//               rst        in  1  synchronous active-high reset
//               req        in  4  level-sensitive request lines
//               ack        in  1  downstream consumed current grant
//               gnt        out 4  registered one-hot grant (zero when idle)
//               gnt_valid  out 1  registered, high exactly when gnt != 0
// Revision    : 1.0 - initial release
// ============================================================================
module week6_ex1_rr_arbiter
    import week6_pkg::*;
`ifdef ARB_LOCK_EN
#(
    parameter int unsigned MAX_HOLD = 4
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             r_gnt_valid;
    logic             w_gnt_valid_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_pick_ptr;
    logic [N_REQ-1:0] w_pick;
    logic             w_handover;

`ifdef ARB_LOCK_EN
    localparam logic [3:0] c_HOLD_LIMIT = 4'(MAX_HOLD - 1);
    logic [3:0] r_hold_cnt;
    logic [3:0] w_hold_cnt_nxt;
`endif

    assign w_gnt_idx  = onehot_to_idx(r_gnt);
    assign w_handover = (r_state == GRANT) && ack;

    // One picker serves both decisions: from IDLE it searches from the stored
    // pointer; on a handover it searches from just past the granted index,
    // which is the value the pointer is about to take.
    assign w_pick_ptr = w_handover ? (w_gnt_idx + 2'd1) : r_ptr;

    week6_rr_pick u_pick (
        .req  (req),
        .ptr  (w_pick_ptr),
        .pick (w_pick)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_ptr_nxt       = r_ptr;
`ifdef ARB_LOCK_EN
        w_hold_cnt_nxt  = r_hold_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_gnt_nxt       = w_pick;
                    w_gnt_valid_nxt = 1'b1;
                    w_state_nxt     = GRANT;
`ifdef ARB_LOCK_EN
                    w_hold_cnt_nxt  = '0;
`endif
                end else begin
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                // Without ack the grant is a commitment, even if req drops.
                if (ack) begin
`ifdef ARB_LOCK_EN
                    if (req[w_gnt_idx] && (r_hold_cnt < c_HOLD_LIMIT)) begin
                        w_hold_cnt_nxt = r_hold_cnt + 4'd1;
                    end else
`endif
                    begin
                        w_ptr_nxt = w_gnt_idx + 2'd1;
`ifdef ARB_LOCK_EN
                        w_hold_cnt_nxt = '0;
`endif
                        if (|w_pick) begin
                            w_gnt_nxt       = w_pick;
                            w_gnt_valid_nxt = 1'b1;
                        end else begin
                            w_gnt_nxt       = '0;
                            w_gnt_valid_nxt = 1'b0;
                            w_state_nxt     = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
`ifdef ARB_LOCK_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_ptr       <= w_ptr_nxt;
`ifdef ARB_LOCK_EN
            r_hold_cnt  <= w_hold_cnt_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;

endmodule : week6_ex1_rr_arbiter
`default_nettype wire

// File: tb/tb_week6_ex1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_week6_ex1_rr_arbiter
// Description : Self-checking bench for week6_ex1_rr_arbiter. A behavioural
//               model predicts {gnt_valid, gnt} for every driven cycle and
//               pushes it to a queue; after the clock edge the entry is
//               popped and compared with the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_week6_ex1_rr_arbiter;

    localparam int c_MODEL_HOLD = 3;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       gnt_valid;

    int n_checks;
    int n_errors;

    logic [4:0] q_exp[$];

    // Model state
    int m_ptr;
    int m_idx;
    int m_valid;
    int m_hold;

`ifdef ARB_LOCK_EN
    week6_ex1_rr_arbiter #(.MAX_HOLD(c_MODEL_HOLD)) dut (
`else
    week6_ex1_rr_arbiter dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge for the given inputs.
    task automatic model_step(input logic r_in, input logic [3:0] rq, input logic ak);
        logic [3:0] g;
        if (r_in) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (m_valid == 0) begin
            if (rq != 4'b0) begin
                m_idx = first_req(rq, m_ptr); m_valid = 1; m_hold = 0;
            end
        end else if (ak) begin
`ifdef ARB_LOCK_EN
            if (rq[m_idx] && m_hold < c_MODEL_HOLD - 1) begin
                m_hold++;
            end else
`endif
            begin
                m_ptr  = (m_idx + 1) % 4;
                m_hold = 0;
                if (rq != 4'b0) m_idx = first_req(rq, m_ptr);
                else            m_valid = 0;
            end
        end
        g = (m_valid != 0) ? (4'b0001 << m_idx) : 4'b0000;
        q_exp.push_back({(m_valid != 0), g});
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input string tag, input logic r_in, input logic [3:0] rq, input logic ak);
        logic [4:0] e;
        rst = r_in; req = rq; ack = ak;
        model_step(r_in, rq, ak);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check_eq({tag, "_gnt"}, {4'b0, gnt}, {4'b0, e[3:0]});
        check_eq({tag, "_valid"}, {7'b0, gnt_valid}, {7'b0, e[4]});
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_ptr = 0; m_idx = 0; m_valid = 0; m_hold = 0;
        rst = 1'b1; req = 4'b0; ack = 1'b0;

        // Reset held with all requests asserted
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 4'b1111, 1'b0);
        step("first_grant", 1'b0, 4'b1111, 1'b0);
        check_eq("first_grant_lit", {4'b0, gnt}, 8'b0000_0001);

        // Rotation with constant ack
        for (int i = 0; i < 4; i++) step("rotate", 1'b0, 4'b1111, 1'b1);

        // Sparse / wrap: grant to 2, then req=0011 with ack
        step("rst2", 1'b1, 4'b0000, 1'b0);
        step("grant2", 1'b0, 4'b0100, 1'b0);
        step("wrap", 1'b0, 4'b0011, 1'b1);
        check_eq("wrap_lit", {4'b0, gnt}, 8'b0000_0001);
        step("wrap_next", 1'b0, 4'b0011, 1'b1);
        check_eq("wrap_next_lit", {4'b0, gnt}, 8'b0000_0010);
        step("to_idle", 1'b0, 4'b0000, 1'b1);

        // Hold without ack after request drops
        step("rst3", 1'b1, 4'b0000, 1'b0);
        step("hold_grant", 1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 4'b0000, 1'b0);
        step("hold_release", 1'b0, 4'b0000, 1'b1);
        check_eq("hold_release_lit", {3'b0, gnt_valid, gnt}, 8'b0);

        // Ack while idle is ignored; request in idle with ack still grants
        step("idle_ack", 1'b0, 4'b0000, 1'b1);
        step("idle_ack_req", 1'b0, 4'b1000, 1'b1);

        // Reset asserted mid-grant
        step("pre_midrst", 1'b0, 4'b1010, 1'b0);
        step("midrst", 1'b1, 4'b1111, 1'b1);
        step("post_midrst", 1'b0, 4'b1111, 1'b0);

`ifdef ARB_LOCK_EN
        step("lock_rst", 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) step("lock", 1'b0, 4'b0011, 1'b1);
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
            check_eq("onehot0", {7'b0, $onehot0(gnt)}, 8'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_week6_ex1_rr_arbiter
`default_nettype wire
